wib_rd_sched: RTL and testbench
===============================

// Module: wib_rd_sched
// PURPOSE
//  Sequences and arbitrates access to the single-port WIB weight RAM.
//  - Turns a core burst command (start addr, length) into consecutive RAM reads.
//  - Shares the RAM port with the AXI BRAM-controller host; bounded host wait.
//  - Steers RAM read data back to the burst consumer or the host.
//  - Sits between the npu_core weight fetch logic / AXI BRAM controller and wib_buffer.
// PARAMETERS
//  ADDR_W      10  RAM word address width; burst addresses wrap modulo 2**ADDR_W
//  DATA_W      19  RAM data width
//  LEN_W       11  burst length width (1..1024 words)
//  RD_LAT      2   cycles from RAM enable to valid RAM data (2 = registered RAM output)
//  STARVE_MAX  8   consecutive blocked host cycles before host is forced one slot
// PORTS
//  i_clk             in   1       clock
//  i_rst             in   1       synchronous reset, active-high
//  i_burst_start     in   1       one-cycle start pulse; ignored while o_burst_busy
//  i_burst_addr      in   ADDR_W  first word address
//  i_burst_len       in   LEN_W   number of words to read
//  o_burst_busy      out  1       burst accepted and not yet complete
//  o_burst_done      out  1       one-cycle pulse: last burst word delivered
//  o_rdat            out  DATA_W  burst read data
//  o_rdat_vld        out  1       o_rdat valid
//  i_host_en         in   1       host request; held until o_host_ready
//  i_host_we         in   1       1 = write, 0 = read
//  i_host_be         in   4       host byte enables
//  i_host_addr       in   12      host address (forwarded unchanged)
//  i_host_wdata      in   32      host write data
//  o_host_ready      out  1       host access issued to RAM this cycle (combinational)
//  o_host_rdata      out  32      {zero-ext, RAM data} for host reads
//  o_host_rvld       out  1       o_host_rdata valid
//  o_ram_rd_en       out  1       to wib_buffer i_wib_rd_en
//  o_ram_raddr       out  ADDR_W  to wib_buffer i_wib_raddr
//  o_ram_bc_en/we/be/addr/wdata   out  1/1/4/12/32  to wib_buffer bramctl port
//  i_ram_rdat        in   DATA_W  from wib_buffer o_wib_rdat
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, except o_ram_raddr and o_rdat, which hold 0.
//    Tag pipe, counters and starvation counter are cleared. Reset mid-burst aborts;
//    no done pulse. Data returning after reset is discarded.
//  FSM:
//    IDLE --start & len!=0--> RUN
//    IDLE --start & len==0--> DONE (no reads issued)
//    RUN --last read issued--> DRAIN
//    DRAIN --tag pipe empty of burst tags--> DONE
//    DONE --> IDLE (o_burst_done=1 for exactly this cycle)
//    o_burst_busy = state != IDLE.
//  Arbitration, per cycle at most one RAM access (never rd_en and bc_en together):
//    - RUN and no host forcing: issue burst read; addr = ptr; ptr <= ptr+1 (wrap).
//    - Else if i_host_en: drive bc_* from host inputs; o_host_ready=1.
//    - Host forcing: starve_cnt counts cycles with i_host_en=1 & o_host_ready=0.
//      At starve_cnt==STARVE_MAX the host wins the next cycle; the burst pauses
//      one cycle and starve_cnt resets. starve_cnt also resets on any host grant.
//  Read return:
//    - RD_LAT-deep tag shift register per issued read: 2'b01 burst, 2'b10 host read.
//    - Tag exits RD_LAT cycles after issue:
//        burst -> o_rdat=i_ram_rdat, o_rdat_vld=1
//        host  -> o_host_rdata, o_host_rvld=1
//    - Host writes produce no tag and no rvld.
//  Width/count: remaining count LEN_W bits, loaded from len, decremented per issued read.
//    Last read issues when remaining==1. Address arithmetic is modulo 2**ADDR_W.
//  Simultaneous events:
//    - i_burst_start in the DONE cycle is ignored.
//    - Host request in the start cycle (IDLE) is granted that cycle; the burst
//      issues from the next cycle.
// TESTING
//  1. Reset, start addr=0x010 len=4, no host
//     -> reads 0x010..0x013 on consecutive cycles
//     -> o_rdat_vld 4 cycles starting RD_LAT after the first read
//     -> done 1 cycle after the last vld.
//  2. addr=0x3FE len=4 -> raddr 0x3FE,0x3FF,0x000,0x001; data matches preloaded RAM.
//  3. len=0 -> busy 1 cycle, done pulse, zero RAM accesses.
//  4. Host read held during len=64 burst, STARVE_MAX=8
//     -> o_host_ready on the 9th blocked cycle; burst stalls one cycle
//     -> host rvld RD_LAT later; burst data order and count intact.
//  5. Host write in IDLE with be=4'b0011 -> bc_we=1, be passed, o_host_ready same cycle, no rvld.
//  6. i_rst mid-burst (after 3 of 16 reads) -> outputs 0 next cycle, no done
//     -> a new burst runs cleanly.

Source files
------------

// File: rtl/wib_rd_sched.sv
// Read scheduler for the single-port WIB weight RAM: turns core burst commands into
// sequential reads, shares the port with the AXI BRAM-controller host, and routes read data back.
module wib_rd_sched #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 19,
  parameter int LEN_W      = 11,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_burst_start,
  input  logic [ADDR_W-1:0] i_burst_addr,
  input  logic [LEN_W-1:0]  i_burst_len,
  output logic              o_burst_busy,
  output logic              o_burst_done,
  output logic [DATA_W-1:0] o_rdat,
  output logic              o_rdat_vld,
  input  logic              i_host_en,
  input  logic              i_host_we,
  input  logic [3:0]        i_host_be,
  input  logic [11:0]       i_host_addr,
  input  logic [31:0]       i_host_wdata,
  output logic              o_host_ready,
  output logic [31:0]       o_host_rdata,
  output logic              o_host_rvld,
  output logic              o_ram_rd_en,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic              o_ram_bc_en,
  output logic              o_ram_bc_we,
  output logic [3:0]        o_ram_bc_be,
  output logic [11:0]       o_ram_bc_addr,
  output logic [31:0]       o_ram_bc_wdata,
  input  logic [DATA_W-1:0] i_ram_rdat
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] TAG_NONE  = 2'b00;
  localparam logic [1:0] TAG_BURST = 2'b01;
  localparam logic [1:0] TAG_HOST  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_ptr;
  logic [LEN_W-1:0]        r_remain;
  logic [SC_W-1:0]         r_starve;
  logic [RD_LAT-1:0][1:0]  r_tag;
  logic [DATA_W-1:0]       r_rdat;

  logic                    w_force;
  logic                    w_burst_rd;
  logic                    w_host_gnt;
  logic [1:0]              w_new_tag;
  logic [1:0]              w_tag_out;
  logic                    w_burst_vld;
  logic                    w_host_vld;
  logic                    w_burst_pend;

  // A host that has waited STARVE_MAX cycles steals exactly one RUN slot.
  assign w_force    = i_host_en && (r_starve == SC_W'(STARVE_MAX));
  assign w_burst_rd = !i_rst && (r_state == S_RUN) && !w_force;
  assign w_host_gnt = !i_rst && i_host_en && !w_burst_rd;

  assign w_new_tag   = w_burst_rd ? TAG_BURST :
                       (w_host_gnt && !i_host_we) ? TAG_HOST : TAG_NONE;
  assign w_tag_out   = r_tag[RD_LAT-1];
  assign w_burst_vld = !i_rst && (w_tag_out == TAG_BURST);
  assign w_host_vld  = !i_rst && (w_tag_out == TAG_HOST);

  // The stage leaving the pipe this cycle is delivered now, so only younger stages keep DRAIN alive.
  always_comb begin
    w_burst_pend = 1'b0;
    for (int k = 0; k < RD_LAT - 1; k++) begin
      if (r_tag[k] == TAG_BURST) w_burst_pend = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_remain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_burst_start) begin
            r_ptr    <= i_burst_addr;
            r_remain <= i_burst_len;
            r_state  <= (i_burst_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_burst_rd) begin
            r_ptr    <= r_ptr + ADDR_W'(1);
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!w_burst_pend) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag    <= '0;
      r_starve <= '0;
      r_rdat   <= '0;
    end else begin
      for (int k = RD_LAT - 1; k > 0; k--) r_tag[k] <= r_tag[k-1];
      r_tag[0] <= w_new_tag;
      if (w_host_gnt)
        r_starve <= '0;
      else if (i_host_en && (r_starve != SC_W'(STARVE_MAX)))
        r_starve <= r_starve + SC_W'(1);
      if (w_burst_vld) r_rdat <= i_ram_rdat;
    end
  end

  assign o_burst_busy   = (r_state != S_IDLE);
  assign o_burst_done   = (r_state == S_DONE);
  assign o_rdat_vld     = w_burst_vld;
  assign o_rdat         = w_burst_vld ? i_ram_rdat : r_rdat;
  assign o_host_rvld    = w_host_vld;
  assign o_host_rdata   = w_host_vld ? {{(32-DATA_W){1'b0}}, i_ram_rdat} : 32'd0;
  assign o_host_ready   = w_host_gnt;
  assign o_ram_rd_en    = w_burst_rd;
  assign o_ram_raddr    = r_ptr;
  assign o_ram_bc_en    = w_host_gnt;
  assign o_ram_bc_we    = w_host_gnt && i_host_we;
  assign o_ram_bc_be    = w_host_gnt ? i_host_be    : 4'd0;
  assign o_ram_bc_addr  = w_host_gnt ? i_host_addr  : 12'd0;
  assign o_ram_bc_wdata = w_host_gnt ? i_host_wdata : 32'd0;

endmodule

// File: tb/tb_wib_rd_sched.sv
// Scoreboard bench for wib_rd_sched: a registered two-stage RAM model feeds the DUT,
// and a negedge monitor pops expected addresses/data as the DUT presents them.
module tb_wib_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        burstStart;
  logic [9:0]  burstAddr;
  logic [10:0] burstLen;
  logic        burstBusy, burstDone;
  logic [18:0] rdat;
  logic        rdatVld;
  logic        hostEn, hostWe;
  logic [3:0]  hostBe;
  logic [11:0] hostAddr;
  logic [31:0] hostWdata;
  logic        hostReady;
  logic [31:0] hostRdata;
  logic        hostRvld;
  logic        ramRdEn;
  logic [9:0]  ramRaddr;
  logic        bcEn, bcWe;
  logic [3:0]  bcBe;
  logic [11:0] bcAddr;
  logic [31:0] bcWdata;
  logic [18:0] ramS1, ramRdat;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int busyCount = 0;
  int doneCount = 0;

  logic [9:0]  expAddrQ[$];
  logic [18:0] expDataQ[$];
  logic [31:0] expHostQ[$];
  int rdCycQ[$];
  int vldCycQ[$];
  int hostRdyCycQ[$];
  int hostVldCycQ[$];

  wib_rd_sched dut (
    .i_clk(clk), .i_rst(rst),
    .i_burst_start(burstStart), .i_burst_addr(burstAddr), .i_burst_len(burstLen),
    .o_burst_busy(burstBusy), .o_burst_done(burstDone),
    .o_rdat(rdat), .o_rdat_vld(rdatVld),
    .i_host_en(hostEn), .i_host_we(hostWe), .i_host_be(hostBe),
    .i_host_addr(hostAddr), .i_host_wdata(hostWdata),
    .o_host_ready(hostReady), .o_host_rdata(hostRdata), .o_host_rvld(hostRvld),
    .o_ram_rd_en(ramRdEn), .o_ram_raddr(ramRaddr),
    .o_ram_bc_en(bcEn), .o_ram_bc_we(bcWe), .o_ram_bc_be(bcBe),
    .o_ram_bc_addr(bcAddr), .o_ram_bc_wdata(bcWdata),
    .i_ram_rdat(ramRdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [18:0] memWord(input logic [9:0] a);
    return {9'h15A, a};
  endfunction

  // RAM content is a fixed function of address; output is registered twice, and idle slots return junk.
  always @(posedge clk) begin
    if (ramRdEn)             ramS1 <= memWord(ramRaddr);
    else if (bcEn && !bcWe)  ramS1 <= memWord(bcAddr[9:0]);
    else                     ramS1 <= 19'h7FFFF;
    ramRdat <= ramS1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT issues a read or presents data.
  always @(negedge clk) begin
    if (burstBusy) busyCount++;
    if (burstDone) doneCount++;
    if (ramRdEn || bcEn) checkOutput("ram_port_exclusive", 64'(ramRdEn & bcEn), 64'd0);
    if (ramRdEn) begin
      rdCycQ.push_back(cyc);
      if (expAddrQ.size() == 0) checkOutput("burst_rd_unexpected", 64'd1, 64'd0);
      else checkOutput("burst_raddr", 64'(ramRaddr), 64'(expAddrQ.pop_front()));
    end
    if (rdatVld) begin
      vldCycQ.push_back(cyc);
      if (expDataQ.size() == 0) checkOutput("burst_vld_unexpected", 64'd1, 64'd0);
      else checkOutput("burst_rdat", 64'(rdat), 64'(expDataQ.pop_front()));
    end
    if (hostReady) hostRdyCycQ.push_back(cyc);
    if (hostRvld) begin
      hostVldCycQ.push_back(cyc);
      if (expHostQ.size() == 0) checkOutput("host_rvld_unexpected", 64'd1, 64'd0);
      else checkOutput("host_rdata", 64'(hostRdata), 64'(expHostQ.pop_front()));
    end
  end

  task automatic clearLogs();
    rdCycQ.delete();
    vldCycQ.delete();
    hostRdyCycQ.delete();
    hostVldCycQ.delete();
    busyCount = 0;
    doneCount = 0;
  endtask

  task automatic pushBurst(input logic [9:0] a);
    expAddrQ.push_back(a);
    expDataQ.push_back(memWord(a));
  endtask

  task automatic applyStimulus(input logic [9:0] addr, input logic [10:0] len, output int startCyc);
    @(posedge clk); #1;
    burstStart = 1'b1;
    burstAddr  = addr;
    burstLen   = len;
    startCyc   = cyc;
    @(posedge clk); #1;
    burstStart = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int doneCyc);
    doneCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (burstDone) begin
        doneCyc = cyc;
        break;
      end
    end
    if (doneCyc < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic hostAccess(input logic we, input logic [3:0] be, input logic [11:0] addr,
                            input logic [31:0] wdata, input int budget,
                            output int driveCyc, output int readyCyc);
    @(posedge clk); #1;
    hostEn = 1'b1; hostWe = we; hostBe = be; hostAddr = addr; hostWdata = wdata;
    driveCyc = cyc;
    readyCyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (hostReady) begin
        readyCyc = cyc;
        checkOutput("bc_we", 64'(bcWe), 64'(we));
        checkOutput("bc_be", 64'(bcBe), 64'(be));
        checkOutput("bc_addr", 64'(bcAddr), 64'(addr));
        checkOutput("bc_wdata", 64'(bcWdata), 64'(wdata));
        if (!we) expHostQ.push_back({13'd0, memWord(addr[9:0])});
        break;
      end
    end
    if (readyCyc < 0) checkOutput("host_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    hostEn = 1'b0; hostWe = 1'b0; hostBe = 4'd0; hostAddr = 12'd0; hostWdata = 32'd0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 64'(burstBusy), 64'd0);
    checkOutput({tag, "_done"}, 64'(burstDone), 64'd0);
    checkOutput({tag, "_rdat_vld"}, 64'(rdatVld), 64'd0);
    checkOutput({tag, "_rdat"}, 64'(rdat), 64'd0);
    checkOutput({tag, "_raddr"}, 64'(ramRaddr), 64'd0);
    checkOutput({tag, "_rd_en"}, 64'(ramRdEn), 64'd0);
    checkOutput({tag, "_host_rvld"}, 64'(hostRvld), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, d, h, r;
    bit found;
    rst = 1'b1;
    burstStart = 1'b0; burstAddr = '0; burstLen = '0;
    hostEn = 1'b0; hostWe = 1'b0; hostBe = '0; hostAddr = '0; hostWdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkQuiet("reset");
    checkOutput("reset_host_ready", 64'(hostReady), 64'd0);
    checkOutput("reset_bc_en", 64'(bcEn), 64'd0);

    $display("[TB] test 1: addr 0x010 len 4");
    clearLogs();
    pushBurst(10'h010); pushBurst(10'h011); pushBurst(10'h012); pushBurst(10'h013);
    applyStimulus(10'h010, 11'd4, s);
    waitDone(40, d);
    @(negedge clk);
    checkOutput("t1_rd_count", 64'(rdCycQ.size()), 64'd4);
    checkOutput("t1_vld_count", 64'(vldCycQ.size()), 64'd4);
    if (rdCycQ.size() == 4 && vldCycQ.size() == 4) begin
      checkOutput("t1_first_rd", 64'(rdCycQ[0]), 64'(s + 1));
      checkOutput("t1_last_rd", 64'(rdCycQ[3]), 64'(s + 4));
      checkOutput("t1_first_vld", 64'(vldCycQ[0]), 64'(s + 3));
      checkOutput("t1_last_vld", 64'(vldCycQ[3]), 64'(s + 6));
    end
    checkOutput("t1_done_cyc", 64'(d), 64'(s + 7));
    checkOutput("t1_busy_cycles", 64'(busyCount), 64'd7);
    checkOutput("t1_busy_after", 64'(burstBusy), 64'd0);

    $display("[TB] test 2: addr 0x3FE len 4 wraps");
    clearLogs();
    pushBurst(10'h3FE); pushBurst(10'h3FF); pushBurst(10'h000); pushBurst(10'h001);
    applyStimulus(10'h3FE, 11'd4, s);
    waitDone(40, d);
    @(negedge clk);
    checkOutput("t2_rd_count", 64'(rdCycQ.size()), 64'd4);
    checkOutput("t2_done_cyc", 64'(d), 64'(s + 7));
    checkOutput("t2_addr_q_empty", 64'(expAddrQ.size()), 64'd0);
    checkOutput("t2_data_q_empty", 64'(expDataQ.size()), 64'd0);

    $display("[TB] test 3: len 0");
    clearLogs();
    applyStimulus(10'h055, 11'd0, s);
    waitDone(10, d);
    @(negedge clk);
    checkOutput("t3_done_cyc", 64'(d), 64'(s + 1));
    checkOutput("t3_busy_cycles", 64'(busyCount), 64'd1);
    checkOutput("t3_rd_count", 64'(rdCycQ.size()), 64'd0);
    checkOutput("t3_host_count", 64'(hostRdyCycQ.size()), 64'd0);

    $display("[TB] test 4: host read starved by len 64 burst");
    clearLogs();
    for (int i = 0; i < 64; i++) pushBurst(10'(10'h100 + i));
    applyStimulus(10'h100, 11'd64, s);
    hostAccess(1'b0, 4'hF, 12'h0AB, 32'd0, 30, h, r);
    waitDone(200, d);
    @(negedge clk);
    checkOutput("t4_host_drive_cyc", 64'(h), 64'(s + 2));
    checkOutput("t4_host_ready_cyc", 64'(r), 64'(h + 8));
    found = 1'b0;
    foreach (rdCycQ[i]) if (rdCycQ[i] == r) found = 1'b1;
    checkOutput("t4_burst_paused", 64'(found), 64'd0);
    checkOutput("t4_rd_count", 64'(rdCycQ.size()), 64'd64);
    if (rdCycQ.size() == 64) checkOutput("t4_last_rd", 64'(rdCycQ[63]), 64'(s + 65));
    checkOutput("t4_host_vld_count", 64'(hostVldCycQ.size()), 64'd1);
    if (hostVldCycQ.size() == 1) checkOutput("t4_host_vld_cyc", 64'(hostVldCycQ[0]), 64'(r + 2));
    checkOutput("t4_done_cyc", 64'(d), 64'(s + 68));
    checkOutput("t4_data_q_empty", 64'(expDataQ.size()), 64'd0);

    $display("[TB] test 5: host write in idle");
    clearLogs();
    hostAccess(1'b1, 4'b0011, 12'h123, 32'hDEADBEEF, 5, h, r);
    repeat (4) @(negedge clk);
    checkOutput("t5_ready_same_cycle", 64'(r), 64'(h));
    checkOutput("t5_no_rvld", 64'(hostVldCycQ.size()), 64'd0);

    $display("[TB] test 6: reset mid-burst");
    clearLogs();
    for (int i = 0; i < 16; i++) pushBurst(10'(10'h200 + i));
    applyStimulus(10'h200, 11'd16, s);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (rdCycQ.size() >= 3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t6_three_reads_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    expAddrQ.delete();
    expDataQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkQuiet("t6_after_reset");
    repeat (5) @(negedge clk);
    checkOutput("t6_no_done", 64'(doneCount), 64'd0);
    checkOutput("t6_rd_count", 64'(rdCycQ.size()), 64'd3);
    checkOutput("t6_vld_count", 64'(vldCycQ.size()), 64'd1);

    clearLogs();
    pushBurst(10'h020); pushBurst(10'h021); pushBurst(10'h022);
    applyStimulus(10'h020, 11'd3, s);
    waitDone(40, d);
    @(negedge clk);
    checkOutput("t6_new_rd_count", 64'(rdCycQ.size()), 64'd3);
    checkOutput("t6_new_vld_count", 64'(vldCycQ.size()), 64'd3);
    checkOutput("t6_new_done_cyc", 64'(d), 64'(s + 6));

    checkOutput("final_addr_q_empty", 64'(expAddrQ.size()), 64'd0);
    checkOutput("final_data_q_empty", 64'(expDataQ.size()), 64'd0);
    checkOutput("final_host_q_empty", 64'(expHostQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
